// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: address/instruction types,
// boolean constants, the default geometry and the index-field range macro.
package inst_cache_pkg;

    localparam int ICACHE_ADDR_WIDTH         = 32;
    localparam int ICACHE_INST_WIDTH         = 32;
    localparam int ICACHE_INDEX_BITS_DEFAULT = 8;

    typedef logic [ICACHE_ADDR_WIDTH-1:0] addr_t;
    typedef logic [ICACHE_INST_WIDTH-1:0] inst_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Tag width left after removing the index and the two byte-offset bits.
    function automatic int icache_tag_bits(input int addr_width, input int index_bits);
        return addr_width - index_bits - 2;
    endfunction

endpackage

// Index field of a byte address: the bits just above the word offset.
`ifndef ICACHE_IDX_RANGE
`define ICACHE_IDX_RANGE(ib) ((ib)+1):2
`endif

// File: rtl/inst_cache_valid_array.sv
// Per-line valid flops for the instruction cache: asynchronous clear on reset,
// single-index set on fill, and whole-array synchronous clear on fence.i.
module inst_cache_valid_array
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS_DEFAULT
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        set_en_i,
    input  logic [INDEX_BITS-1:0]       set_idx_i,
    input  logic                        clr_i,
    output logic [(1<<INDEX_BITS)-1:0]  valid_o
);

    localparam int LINES = 1 << INDEX_BITS;

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_line
            logic valid_q;
            logic valid_d;

            // Clear has priority so a fill racing a fence.i is dropped.
            always_comb begin
                valid_d = valid_q;
                if (clr_i) begin
                    valid_d = FALSE;
                end else if (set_en_i && (set_idx_i == INDEX_BITS'(gi))) begin
                    valid_d = TRUE;
                end
            end

            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    valid_q <= FALSE;
                end else begin
                    valid_q <= valid_d;
                end
            end

            assign valid_o[gi] = valid_q;
        end
    endgenerate

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with combinational lookup.
// Define ICACHE_BYPASS_EN to forward a fill to a same-cycle matching lookup.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS_DEFAULT,
    parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic [ADDR_WIDTH-1:0]  if_to_ic_fetch_addr,
    output logic                   ic_to_if_hit,
    output logic [31:0]            ic_to_if_hit_inst,
    input  logic [ADDR_WIDTH-1:0]  if_to_ic_update_addr,
    input  logic [31:0]            if_to_ic_inst,
    input  logic                   if_to_ic_inst_valid,
    input  logic                   rob_to_ic_inv
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = icache_tag_bits(ADDR_WIDTH, INDEX_BITS);

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];
    logic [LINES-1:0]      valid_vec;

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  fill_we;
    logic                  inv_en;
    logic                  array_hit;
    logic                  unused_offsets;

    assign fetch_idx = if_to_ic_fetch_addr[`ICACHE_IDX_RANGE(INDEX_BITS)];
    assign fetch_tag = if_to_ic_fetch_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign upd_idx   = if_to_ic_update_addr[`ICACHE_IDX_RANGE(INDEX_BITS)];
    assign upd_tag   = if_to_ic_update_addr[ADDR_WIDTH-1:INDEX_BITS+2];

    // Byte offsets never participate: lines hold one aligned word.
    assign unused_offsets = ^{if_to_ic_fetch_addr[1:0], if_to_ic_update_addr[1:0]};

    assign fill_we = rst_in && rdy_in && if_to_ic_inst_valid && !rob_to_ic_inv;
    assign inv_en  = rdy_in && rob_to_ic_inv;

    inst_cache_valid_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_valid (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .set_en_i  (fill_we),
        .set_idx_i (upd_idx),
        .clr_i     (inv_en),
        .valid_o   (valid_vec)
    );

    // Tag and data carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            tag_mem[upd_idx]  <= upd_tag;
            data_mem[upd_idx] <= if_to_ic_inst;
        end
    end

    assign array_hit = valid_vec[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);

`ifdef ICACHE_BYPASS_EN
    logic bypass_hit;

    // Forwarding is suppressed during reset so hit falls as soon as reset asserts.
    assign bypass_hit = rst_in && if_to_ic_inst_valid &&
                        (if_to_ic_update_addr[ADDR_WIDTH-1:2] == if_to_ic_fetch_addr[ADDR_WIDTH-1:2]);

    always_comb begin
        ic_to_if_hit      = array_hit || bypass_hit;
        ic_to_if_hit_inst = 32'h0;
        if (bypass_hit) begin
            ic_to_if_hit_inst = if_to_ic_inst;
        end else if (array_hit) begin
            ic_to_if_hit_inst = data_mem[fetch_idx];
        end
    end
`else
    always_comb begin
        ic_to_if_hit      = array_hit;
        ic_to_if_hit_inst = array_hit ? data_mem[fetch_idx] : 32'h0;
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache (default geometry, INDEX_BITS=8).
module tb_inst_cache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] fetch_addr;
    logic        hit;
    logic [31:0] hit_inst;
    logic [31:0] upd_addr;
    logic [31:0] upd_inst;
    logic        inst_valid;
    logic        inv;

    int tests_run = 0;
    int tests_failed = 0;

    inst_cache dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .rdy_in               (rdy_in),
        .if_to_ic_fetch_addr  (fetch_addr),
        .ic_to_if_hit         (hit),
        .ic_to_if_hit_inst    (hit_inst),
        .if_to_ic_update_addr (upd_addr),
        .if_to_ic_inst        (upd_inst),
        .if_to_ic_inst_valid  (inst_valid),
        .rob_to_ic_inv        (inv)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One fill transaction: strobe high across exactly one rising edge.
    task automatic do_fill(input logic [31:0] addr, input logic [31:0] inst);
        @(negedge clk_in);
        upd_addr   = addr;
        upd_inst   = inst;
        inst_valid = 1'b1;
        @(negedge clk_in);
        inst_valid = 1'b0;
        $display("[TB] fill addr=%08h inst=%08h", addr, inst);
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        fetch_addr = 32'h0000_0000;
        #1;
        tests_run++;
        if (hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hit_0: got %0b want 0", hit);
        end
        tests_run++;
        if (hit_inst !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_inst_0: got %08h want 00000000", hit_inst);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        fetch_addr = 32'h0000_03FC;
        #1;
        tests_run++;
        if (hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hit_3fc: got %0b want 0", hit);
        end
        $display("[TB] reset lookups done");
    endtask

    task automatic test_fill_hit();
        do_fill(32'h0000_1004, 32'h0050_0093);
        fetch_addr = 32'h0000_1004;
        #1;
        tests_run++;
        if (hit !== 1'b1 || hit_inst !== 32'h0050_0093) begin
            tests_failed++;
            $display("FAIL fill_hit_1004: got hit=%0b inst=%08h want hit=1 inst=00500093", hit, hit_inst);
        end
        fetch_addr = 32'h0000_1006;
        #1;
        tests_run++;
        if (hit !== 1'b1 || hit_inst !== 32'h0050_0093) begin
            tests_failed++;
            $display("FAIL fill_offset_1006: got hit=%0b inst=%08h want hit=1 inst=00500093", hit, hit_inst);
        end
        fetch_addr = 32'h0000_2004;
        #1;
        tests_run++;
        if (hit !== 1'b0 || hit_inst !== 32'h0) begin
            tests_failed++;
            $display("FAIL fill_tag_2004: got hit=%0b inst=%08h want hit=0 inst=00000000", hit, hit_inst);
        end
        fetch_addr = 32'h0000_1008;
        #1;
        tests_run++;
        if (hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_idx_1008: got %0b want 0", hit);
        end
    endtask

    task automatic test_conflict();
        do_fill(32'h0000_0010, 32'h1111_1111);
        do_fill(32'h0000_0410, 32'h2222_2222);
        fetch_addr = 32'h0000_0010;
        #1;
        tests_run++;
        if (hit !== 1'b0 || hit_inst !== 32'h0) begin
            tests_failed++;
            $display("FAIL conflict_old_0010: got hit=%0b inst=%08h want hit=0 inst=00000000", hit, hit_inst);
        end
        fetch_addr = 32'h0000_0410;
        #1;
        tests_run++;
        if (hit !== 1'b1 || hit_inst !== 32'h2222_2222) begin
            tests_failed++;
            $display("FAIL conflict_new_0410: got hit=%0b inst=%08h want hit=1 inst=22222222", hit, hit_inst);
        end
    endtask

    task automatic test_invalidate();
        do_fill(32'h0000_0000, 32'hAAAA_0000);
        do_fill(32'h0000_0004, 32'hAAAA_0004);
        @(negedge clk_in);
        inv        = 1'b1;
        upd_addr   = 32'h0000_0008;
        upd_inst   = 32'hAAAA_0008;
        inst_valid = 1'b1;
        fetch_addr = 32'h0000_0004;
        #1;
        tests_run++;
        if (hit !== 1'b1 || hit_inst !== 32'hAAAA_0004) begin
            tests_failed++;
            $display("FAIL inv_preedge_0004: got hit=%0b inst=%08h want hit=1 inst=aaaa0004", hit, hit_inst);
        end
        @(negedge clk_in);
        inv        = 1'b0;
        inst_valid = 1'b0;
        $display("[TB] fence.i with concurrent fill of 00000008");
        for (int i = 0; i < 3; i++) begin
            fetch_addr = 32'(i * 4);
            #1;
            tests_run++;
            if (hit !== 1'b0) begin
                tests_failed++;
                $display("FAIL inv_miss_%08h: got %0b want 0", fetch_addr, hit);
            end
        end
    endtask

    task automatic test_rdy_gating();
        @(negedge clk_in);
        rdy_in     = 1'b0;
        upd_addr   = 32'h0000_0020;
        upd_inst   = 32'hCAFE_0020;
        inst_valid = 1'b1;
        @(negedge clk_in);
        inst_valid = 1'b0;
        rdy_in     = 1'b1;
        fetch_addr = 32'h0000_0020;
        #1;
        tests_run++;
        if (hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL rdy_lost_fill: got %0b want 0", hit);
        end
        do_fill(32'h0000_0020, 32'hCAFE_0020);
        #1;
        tests_run++;
        if (hit !== 1'b1 || hit_inst !== 32'hCAFE_0020) begin
            tests_failed++;
            $display("FAIL rdy_fill: got hit=%0b inst=%08h want hit=1 inst=cafe0020", hit, hit_inst);
        end
        @(negedge clk_in);
        rdy_in = 1'b0;
        inv    = 1'b1;
        @(negedge clk_in);
        rdy_in = 1'b1;
        inv    = 1'b0;
        #1;
        tests_run++;
        if (hit !== 1'b1) begin
            tests_failed++;
            $display("FAIL rdy_inv_held: got %0b want 1", hit);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_in);
        inst_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            upd_addr = 32'h0000_0100 + 32'(i * 4);
            upd_inst = 32'hA000_0100 + 32'(i * 4);
            @(negedge clk_in);
        end
        inst_valid = 1'b0;
        $display("[TB] back-to-back fills 00000100..0000011c");
        for (int i = 0; i < 8; i++) begin
            fetch_addr = 32'h0000_0100 + 32'(i * 4);
            #1;
            tests_run++;
            if (hit !== 1'b1 || hit_inst !== (32'hA000_0100 + 32'(i * 4))) begin
                tests_failed++;
                $display("FAIL b2b_%08h: got hit=%0b inst=%08h want hit=1 inst=%08h",
                         fetch_addr, hit, hit_inst, 32'hA000_0100 + 32'(i * 4));
            end
        end
    endtask

    task automatic test_same_cycle();
        logic exp_now;
`ifdef ICACHE_BYPASS_EN
        exp_now = 1'b1;
`else
        exp_now = 1'b0;
`endif
        @(negedge clk_in);
        fetch_addr = 32'h0000_0040;
        upd_addr   = 32'h0000_0040;
        upd_inst   = 32'hDEAD_BEEF;
        inst_valid = 1'b1;
        #1;
        tests_run++;
        if (hit !== exp_now) begin
            tests_failed++;
            $display("FAIL same_cycle_hit: got %0b want %0b", hit, exp_now);
        end
        @(negedge clk_in);
        inst_valid = 1'b0;
        #1;
        tests_run++;
        if (hit !== 1'b1 || hit_inst !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL same_cycle_next: got hit=%0b inst=%08h want hit=1 inst=deadbeef", hit, hit_inst);
        end
        #1;
        rst_in = 1'b0;
        #1;
        tests_run++;
        if (hit !== 1'b0 || hit_inst !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset_drop: got hit=%0b inst=%08h want hit=0 inst=00000000", hit, hit_inst);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        $display("[TB] same-cycle fill/lookup and async reset done");
    endtask

    initial begin
        rst_in     = 1'b0;
        rdy_in     = 1'b1;
        fetch_addr = 32'h0;
        upd_addr   = 32'h0;
        upd_inst   = 32'h0;
        inst_valid = 1'b0;
        inv        = 1'b0;

        test_reset();
        test_fill_hit();
        test_conflict();
        test_invalidate();
        test_rdy_gating();
        test_back_to_back();
        test_same_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
